bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary converter. It turns a packed multi-digit BCD value (default 5 digits, 00000–99999) into an unsigned binary word and is the inverse path to the pipelined binary-to-BCD display converter. It is used where digit-entry values (parameter setup, keypad/UART digit strings) must become binary control words. It uses one multiply-by-10-accumulate step per cycle (MSD first), a start/busy/valid handshake, digit validity checking and output saturation.

---
 rtl/bcd_to_bin_seq.sv | 123 ++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter: one multiply-by-10-accumulate step per
// cycle, MSD first, with invalid-digit flagging and saturation at 2^BIN_WIDTH-1.
module bcd_to_bin_seq #(
   parameter int BIN_WIDTH  = 16,
   parameter int BCD_DIGITS = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*BCD_DIGITS-1:0] bcd_in,
   input  logic                    convert_en,
   output logic                    busy,
   output logic [BIN_WIDTH-1:0]    bin_out,
   output logic                    valid,
   output logic                    overflow,
   output logic                    err_digit
);

   localparam int ACC_W = 4 * BCD_DIGITS;
   localparam int IDX_W = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [ACC_W-1:0]         cap_q;
   logic [ACC_W-1:0]         acc_q;
   logic [IDX_W-1:0]         idx_q;
   logic                     digit_bad_q;
   logic [BIN_WIDTH-1:0]     bin_q;
   logic                     valid_q;
   logic                     overflow_q;
   logic                     err_q;

   logic                     bad_in;
   logic [3:0]               digit;
   logic [ACC_W-1:0]         acc_next;
   logic [ACC_W+BIN_WIDTH-1:0] acc_wide;
   logic                     too_big;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (convert_en) state_d = CALC;
         CALC:    if (idx_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Any nibble above 9 in the captured word poisons the whole conversion.
   always_comb begin
      bad_in = 1'b0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) bad_in = 1'b1;
      end
   end

   assign digit    = cap_q[4*int'(idx_q) +: 4];
   assign acc_next = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit);
   assign acc_wide = {{BIN_WIDTH{1'b0}}, acc_q};
   assign too_big  = |(acc_wide >> BIN_WIDTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_q       <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         digit_bad_q <= 1'b0;
         bin_q       <= '0;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (convert_en) begin
                  cap_q       <= bcd_in;
                  acc_q       <= '0;
                  idx_q       <= IDX_W'(BCD_DIGITS - 1);
                  digit_bad_q <= bad_in;
               end
            end
            CALC: begin
               acc_q <= acc_next;
               if (idx_q != '0) idx_q <= idx_q - 1'b1;
            end
            DONE: begin
               valid_q <= 1'b1;
               if (digit_bad_q) begin
                  bin_q      <= '0;
                  err_q      <= 1'b1;
                  overflow_q <= 1'b0;
               end else if (too_big) begin
                  bin_q      <= '1;
                  err_q      <= 1'b0;
                  overflow_q <= 1'b1;
               end else begin
                  bin_q      <= acc_wide[BIN_WIDTH-1:0];
                  err_q      <= 1'b0;
                  overflow_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign bin_out   = bin_q;
   assign valid     = valid_q;
   assign overflow  = overflow_q;
   assign err_digit = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: latency, saturation, bad digits, busy-ignore,
// back-to-back restarts and mid-conversion reset.
module tb_bcd_to_bin_seq;

   logic        clk;
   logic        rst_n;
   logic [19:0] bcd_in;
   logic        convert_en;
   logic        busy;
   logic [15:0] bin_out;
   logic        valid;
   logic        overflow;
   logic        err_digit;

   int n_cmp = 0;
   int n_err = 0;

   bcd_to_bin_seq #(.BIN_WIDTH(16), .BCD_DIGITS(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bcd_in     (bcd_in),
      .convert_en (convert_en),
      .busy       (busy),
      .bin_out    (bin_out),
      .valid      (valid),
      .overflow   (overflow),
      .err_digit  (err_digit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Start one conversion, then sample each falling edge until valid (bounded).
   task automatic do_conv(input string tag, input logic [19:0] bcd,
                          input logic [15:0] exp_bin, input logic exp_ovf,
                          input logic exp_err);
      int lat;
      int busy_cnt;
      bit seen;
      lat = -1;
      busy_cnt = 0;
      seen = 0;
      bcd_in = bcd;
      convert_en = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         convert_en = 1'b0;
         if (busy) busy_cnt++;
         if (valid) begin
            seen = 1;
            lat = n;
         end
      end
      check({tag, "_latency"}, lat, 6);
      check({tag, "_busy_cycles"}, busy_cnt, 6);
      check({tag, "_bin"}, bin_out, exp_bin);
      check({tag, "_ovf"}, overflow, exp_ovf);
      check({tag, "_err"}, err_digit, exp_err);
      @(negedge clk);
      check({tag, "_valid_single"}, valid, 0);
   endtask

   initial begin
      int vcnt;
      int last_n;
      bit bad_seen;

      rst_n = 1'b0;
      bcd_in = '0;
      convert_en = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_bin", bin_out, 0);
      check("rst_valid", valid, 0);
      check("rst_ovf", overflow, 0);
      check("rst_err", err_digit, 0);
      rst_n = 1'b1;
      @(negedge clk);

      do_conv("t1_12345", 20'h12345, 16'h3039, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("t1_hold_bin", bin_out, 16'h3039);

      do_conv("t2_65535", 20'h65535, 16'hFFFF, 1'b0, 1'b0);
      do_conv("t2_65536", 20'h65536, 16'hFFFF, 1'b1, 1'b0);
      do_conv("t2_99999", 20'h99999, 16'hFFFF, 1'b1, 1'b0);
      do_conv("t3_zero", 20'h00000, 16'h0000, 1'b0, 1'b0);
      do_conv("t3_bad", 20'h1A000, 16'h0000, 1'b0, 1'b1);
      do_conv("t3_after_bad", 20'h00001, 16'h0001, 1'b0, 1'b0);

      // Start 42, then poke a second start and alter bcd_in while busy.
      bcd_in = 20'h00042;
      convert_en = 1'b1;
      @(posedge clk);
      vcnt = 0;
      last_n = -1;
      for (int n = 0; n < 18; n++) begin
         @(negedge clk);
         if (valid) begin
            vcnt++;
            last_n = n;
            check("t4_bin", bin_out, 16'd42);
         end
         convert_en = (n == 1);
         if (n == 1) bcd_in = 20'h00777;
         if (n == 3) bcd_in = 20'h99999;
      end
      check("t4_valid_count", vcnt, 1);
      check("t4_valid_at", last_n, 6);

      // convert_en held high: a restart on every IDLE cycle.
      bcd_in = 20'h00100;
      convert_en = 1'b1;
      @(posedge clk);
      vcnt = 0;
      last_n = -1;
      bad_seen = 0;
      for (int n = 0; n <= 20; n++) begin
         @(negedge clk);
         if (valid) begin
            vcnt++;
            if (last_n >= 0) check("t5_spacing", n - last_n, 7);
            else check("t5_first", n, 6);
            last_n = n;
            check("t5_bin", bin_out, 16'd100);
         end
      end
      convert_en = 1'b0;
      check("t5_valid_count", vcnt, 3);
      repeat (3) @(negedge clk);

      // Reset in the middle of a CALC aborts with no valid pulse.
      bcd_in = 20'h54321;
      convert_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      convert_en = 1'b0;
      @(negedge clk);
      check("t6_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", busy, 0);
      check("t6_rst_bin", bin_out, 0);
      check("t6_rst_valid", valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (valid) bad_seen = 1;
      end
      check("t6_no_valid", bad_seen, 0);
      do_conv("t6_after", 20'h00009, 16'd9, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
